// File: rtl/bsg_upstream_out_sched.sv
// bsg_upstream_out_sched
//
// Scheduler/sequencer for the upstream off-chip output link. Picks one of
// NUM_REQ core-side requesters per word, then serializes the 64-bit word onto
// two 8-bit channels over four beats (16 bits per beat, low half-word first).
// Word issue is gated by a credit window: sent_cnt counts issued words,
// finish_cnt counts returned tokens, and a word may only be issued while
// (sent_cnt - finish_cnt) mod 2^CNT_W is below CREDIT_MAX.
//
// Build option: define BSG_UPSTREAM_OUT_SCHED_RR_EN for round-robin
// arbitration; leave it undefined for fixed priority (lowest index wins).
//
// Ports:
//   clk             - clock, all logic on posedge
//   rst             - synchronous active-low reset
//   req_valid_i     - per-requester word valid
//   req_data_i      - requester r word at [64r+63:64r]
//   req_ready_o     - one-hot grant, word moves on valid & ready
//   io_token        - credit return, one pulse per word
//   io_valid_out    - beat on the channels is valid
//   io_data_out_ch0 - low byte of the current half-word
//   io_data_out_ch1 - high byte of the current half-word
//   grant_id_o      - requester whose word is on the link
//   credits_avail_o - CREDIT_MAX minus outstanding words
//   token_err_o     - sticky: token arrived with nothing outstanding

module bsg_upstream_out_sched #(
  parameter int NUM_REQ    = 2,
  parameter int CREDIT_MAX = 64,
  parameter int CNT_W      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [64*NUM_REQ-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic                   io_token,
  output logic                   io_valid_out,
  output logic [7:0]             io_data_out_ch0,
  output logic [7:0]             io_data_out_ch1,
  output logic [1:0]             grant_id_o,
  output logic [CNT_W-1:0]       credits_avail_o,
  output logic                   token_err_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       beat_reg, beat_next;
  logic [63:0]      word_reg, word_next;
  logic [CNT_W-1:0] sent_cnt_reg, sent_cnt_next;
  logic [CNT_W-1:0] finish_cnt_reg, finish_cnt_next;
  logic             token_err_reg, token_err_next;
  logic [1:0]       grant_id_reg, grant_id_next;

  // Requests padded out to four lanes so a 2-bit index is always exact.
  logic [3:0]       valid_ext;
  logic [63:0]      word_ext [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < NUM_REQ) begin : g_used
        assign valid_ext[gi] = req_valid_i[gi];
        assign word_ext[gi]  = req_data_i[64*gi +: 64];
      end else begin : g_pad
        assign valid_ext[gi] = 1'b0;
        assign word_ext[gi]  = '0;
      end
    end
  endgenerate

  logic [CNT_W-1:0] outstanding;
  logic             can_issue;
  logic             accept_slot;
  logic             accept;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [3:0]       grant_oh;

  // Modular difference keeps working after either counter wraps.
  assign outstanding     = sent_cnt_reg - finish_cnt_reg;
  assign can_issue       = outstanding < CNT_W'(CREDIT_MAX);
  assign credits_avail_o = CNT_W'(CREDIT_MAX) - outstanding;

  // The last beat of a word is also an accept slot, so words chain with no gap.
  assign accept_slot = (state_reg == IDLE) || (beat_reg == 2'd3);
  assign accept      = accept_slot && can_issue && pick_valid;

`ifdef BSG_UPSTREAM_OUT_SCHED_RR_EN
  logic [1:0] rr_ptr_reg, rr_ptr_next;
  logic [2:0] cand;

  // Search starts one past the last winner and wraps at NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr_reg} + 3'(off);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end
      if (!pick_valid && valid_ext[cand[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[1:0];
      end
    end
  end
`else
  // Scanning downward lets the lowest valid index overwrite the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_ext[i[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = i[1:0];
      end
    end
  end
`endif

  assign grant_oh    = 4'b0001 << pick_idx;
  assign req_ready_o = accept ? grant_oh[NUM_REQ-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      word_reg       <= '0;
      sent_cnt_reg   <= '0;
      finish_cnt_reg <= '0;
      token_err_reg  <= 1'b0;
      grant_id_reg   <= '0;
`ifdef BSG_UPSTREAM_OUT_SCHED_RR_EN
      rr_ptr_reg     <= 2'(NUM_REQ - 1);
`endif
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      word_reg       <= word_next;
      sent_cnt_reg   <= sent_cnt_next;
      finish_cnt_reg <= finish_cnt_next;
      token_err_reg  <= token_err_next;
      grant_id_reg   <= grant_id_next;
`ifdef BSG_UPSTREAM_OUT_SCHED_RR_EN
      rr_ptr_reg     <= rr_ptr_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    word_next       = word_reg;
    sent_cnt_next   = sent_cnt_reg;
    finish_cnt_next = finish_cnt_reg;
    token_err_next  = token_err_reg;
    grant_id_next   = grant_id_reg;
`ifdef BSG_UPSTREAM_OUT_SCHED_RR_EN
    rr_ptr_next     = rr_ptr_reg;
`endif

    if (accept) begin
      word_next     = word_ext[pick_idx];
      beat_next     = 2'd0;
      state_next    = SEND;
      sent_cnt_next = sent_cnt_reg + CNT_W'(1);
      grant_id_next = pick_idx;
`ifdef BSG_UPSTREAM_OUT_SCHED_RR_EN
      rr_ptr_next   = pick_idx;
`endif
    end else if (state_reg == SEND) begin
      if (beat_reg == 2'd3) begin
        // word_reg is left alone so the channels hold the final beat.
        state_next = IDLE;
        beat_next  = 2'd0;
      end else begin
        beat_next = beat_reg + 2'd1;
        word_next = {16'h0000, word_reg[63:16]};
      end
    end

    // Uses the registered count, so a token never frees a slot in its own cycle.
    if (io_token) begin
      if (outstanding != '0) begin
        finish_cnt_next = finish_cnt_reg + CNT_W'(1);
      end else begin
        token_err_next = 1'b1;
      end
    end
  end

  // Current beat always sits in the low half-word of the shift register.
  assign io_valid_out    = (state_reg == SEND);
  assign io_data_out_ch0 = word_reg[7:0];
  assign io_data_out_ch1 = word_reg[15:8];
  assign grant_id_o      = grant_id_reg;
  assign token_err_o     = token_err_reg;

endmodule

// File: tb/tb_bsg_upstream_out_sched.sv
module tb_bsg_upstream_out_sched;

  localparam int NUM_REQ    = 2;
  localparam int CREDIT_MAX = 64;
  localparam int CNT_W      = 7;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [64*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic                  io_token = 1'b0;
  logic                  io_valid_out;
  logic [7:0]            io_data_out_ch0;
  logic [7:0]            io_data_out_ch1;
  logic [1:0]            grant_id_o;
  logic [CNT_W-1:0]      credits_avail_o;
  logic                  token_err_o;

  bsg_upstream_out_sched #(
    .NUM_REQ(NUM_REQ), .CREDIT_MAX(CREDIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready_o),
    .io_token(io_token), .io_valid_out(io_valid_out),
    .io_data_out_ch0(io_data_out_ch0), .io_data_out_ch1(io_data_out_ch1),
    .grant_id_o(grant_id_o), .credits_avail_o(credits_avail_o),
    .token_err_o(token_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] g;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    checks_on = 0;
  bit    flush_q = 0;

  // Requester-side stimulus state
  bit          req_v [NUM_REQ];
  logic [63:0] req_d [NUM_REQ];
  bit          tok = 0;
  bit          keep_busy = 0;

  // Reference model: the link is a 4-cycle resource, credits are a count
  int outstanding = 0;
  bit terr = 0;
  int last_grant = NUM_REQ - 1;
  int beats_left = 0;
  bit cur_acc = 0;
  int cur_g = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic int pick(input bit [3:0] v, input int last);
`ifdef BSG_UPSTREAM_OUT_SCHED_RR_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
`else
    for (int c = 0; c < NUM_REQ; c++) begin
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_cycle();
    bit [3:0]   v;
    int         g;
    int         out_pre;
    bit         acc;
    logic [63:0] exp_ready;
    beat_t      b;
    v = '0;
    for (int k = 0; k < NUM_REQ; k++) v[k] = req_v[k];
    cur_acc = 0;
    cur_g = -1;
    if (checks_on) begin
      chk("io_valid_out", 64'(io_valid_out), 64'(beats_left > 0));
      chk("credits_avail_o", 64'(credits_avail_o), 64'(CREDIT_MAX - outstanding));
      chk("token_err_o", 64'(token_err_o), 64'(terr));
    end
    if (rst == 1'b0) begin
      outstanding = 0;
      terr = 0;
      last_grant = NUM_REQ - 1;
      beats_left = 0;
      flush_q = 1;
      return;
    end
    out_pre = outstanding;
    g = pick(v, last_grant);
    acc = (beats_left <= 1) && (out_pre < CREDIT_MAX) && (g >= 0);
    exp_ready = acc ? (64'd1 << g) : 64'd0;
    if (checks_on) chk("req_ready_o", 64'(req_ready_o), exp_ready);
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        b.c0 = req_d[g][16*k +: 8];
        b.c1 = req_d[g][16*k+8 +: 8];
        b.g  = 2'(g);
        exp_q.push_back(b);
      end
      beats_left = 4;
      last_grant = g;
      outstanding++;
      cur_acc = 1;
      cur_g = g;
    end else if (beats_left > 0) begin
      beats_left--;
    end
    if (tok) begin
      if (out_pre > 0) outstanding--;
      else terr = 1;
    end
  endtask

  // One clock: drive at posedge+1, check/model at negedge, advance.
  task automatic step();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid[k] = req_v[k];
      req_data[64*k +: 64] = req_d[k];
    end
    io_token = tok;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (flush_q) begin
      exp_q.delete();
      flush_q = 0;
    end
    if (cur_acc) begin
      if (keep_busy) req_d[cur_g] = rand64();
      else req_v[cur_g] = 0;
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < NUM_REQ; k++) req_v[k] = 0;
    tok = 0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks_on = 1;
  endtask

  // Monitor: every valid beat must match the oldest expected beat
  always @(negedge clk) begin
    if (checks_on && io_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(io_valid_out), 64'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_ch0", 64'(io_data_out_ch0), 64'(e.c0));
        chk("beat_ch1", 64'(io_data_out_ch1), 64'(e.c1));
        chk("beat_grant", 64'(grant_id_o), 64'(e.g));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int gq[$];
    for (int k = 0; k < NUM_REQ; k++) begin
      req_v[k] = 0;
      req_d[k] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    chk("rst_valid", 64'(io_valid_out), 64'd0);
    chk("rst_ch0", 64'(io_data_out_ch0), 64'd0);
    chk("rst_ch1", 64'(io_data_out_ch1), 64'd0);
    chk("rst_grant", 64'(grant_id_o), 64'd0);
    chk("rst_credits", 64'(credits_avail_o), 64'(CREDIT_MAX));
    chk("rst_token_err", 64'(token_err_o), 64'd0);
    $display("txn reset: credits=%0d", credits_avail_o);

    // Single known word from requester 0
    keep_busy = 0;
    req_v[0] = 1;
    req_d[0] = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 6; i++) step();
    chk("single_credits", 64'(credits_avail_o), 64'(CREDIT_MAX - 1));
    chk("single_last_ch0", 64'(io_data_out_ch0), 64'h23);
    chk("single_last_ch1", 64'(io_data_out_ch1), 64'h01);
    $display("txn single word: credits=%0d", credits_avail_o);

    // Both requesters busy: back-to-back grants
    do_reset();
    keep_busy = 1;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_v[k] = 1;
      req_d[k] = rand64();
    end
    for (int i = 0; i < 17; i++) begin
      step();
      if (cur_acc) gq.push_back(cur_g);
    end
    chk("b2b_count", 64'(gq.size()), 64'd5);
    for (int i = 0; i < 4; i++) begin
`ifdef BSG_UPSTREAM_OUT_SCHED_RR_EN
      chk("b2b_grant", 64'(gq[i]), 64'(i % 2));
`else
      chk("b2b_grant", 64'(gq[i]), 64'd0);
`endif
      $display("txn b2b word %0d granted to %0d", i, gq[i]);
    end

    // Window full: no tokens
    do_reset();
    keep_busy = 1;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_v[k] = 1;
      req_d[k] = rand64();
    end
    cnt = 0;
    for (int i = 0; i < 4 * CREDIT_MAX + 12; i++) begin
      step();
      if (cur_acc) cnt++;
    end
    chk("full_count", 64'(cnt), 64'(CREDIT_MAX));
    chk("full_ready", 64'(req_ready_o), 64'd0);
    chk("full_valid", 64'(io_valid_out), 64'd0);
    chk("full_credits", 64'(credits_avail_o), 64'd0);
    cnt = 0;
    tok = 1;
    step();
    if (cur_acc) cnt++;
    tok = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cur_acc) cnt++;
    end
    chk("full_one_token", 64'(cnt), 64'd1);
    $display("txn window full: one token gave %0d word(s)", cnt);

    // Token together with an accept at outstanding=10
    do_reset();
    keep_busy = 1;
    req_v[0] = 1;
    req_d[0] = rand64();
    for (int i = 0; i < 100; i++) begin
      if (outstanding == 10 && beats_left <= 1) begin
        tok = 1;
        step();
        tok = 0;
        chk("tokacc_accept", 64'(cur_acc), 64'd1);
        chk("tokacc_credits", 64'(credits_avail_o), 64'(CREDIT_MAX - 10));
        $display("txn token+accept: credits=%0d", credits_avail_o);
        break;
      end
      step();
    end

    // Token at reset state
    do_reset();
    tok = 1;
    step();
    tok = 0;
    chk("tokerr_flag", 64'(token_err_o), 64'd1);
    chk("tokerr_credits", 64'(credits_avail_o), 64'(CREDIT_MAX));
    chk("tokerr_valid", 64'(io_valid_out), 64'd0);
    step();
    chk("tokerr_sticky", 64'(token_err_o), 64'd1);
    $display("txn token at reset state: token_err=%0b", token_err_o);

    // Reset during beat 2
    do_reset();
    keep_busy = 0;
    req_v[0] = 1;
    req_d[0] = rand64();
    for (int i = 0; i < 10 && beats_left != 2; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_valid", 64'(io_valid_out), 64'd0);
    chk("midrst_credits", 64'(credits_avail_o), 64'(CREDIT_MAX));
    keep_busy = 1;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_v[k] = 1;
      req_d[k] = rand64();
    end
    cnt = -1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cur_acc) begin
        cnt = cur_g;
        break;
      end
    end
    chk("midrst_first_grant", 64'(cnt), 64'd0);
    $display("txn reset mid-word: next grant=%0d", cnt);

    // Randomized traffic with alternating generous/scarce credit return
    do_reset();
    keep_busy = 0;
    for (int i = 0; i < 2400; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req_v[k] && ($urandom % 2 == 0)) begin
          req_v[k] = 1;
          req_d[k] = rand64();
        end
      end
      if (outstanding > 0) tok = (((i / 400) % 2) == 0) ? ($urandom % 3 == 0) : ($urandom % 12 == 0);
      else tok = ($urandom % 60 == 0);
      step();
      if (cur_acc) $display("txn rand cycle %0d grant=%0d outstanding=%0d", i, cur_g, outstanding);
    end
    tok = 0;
    for (int k = 0; k < NUM_REQ; k++) req_v[k] = 0;
    for (int i = 0; i < 8; i++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
